// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: free-running pixel/line counters,
// visible-area flag, delayed active-low syncs and frame pacing outputs.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        sync,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        h_last, v_last, frame_wrap;
    logic        hsync_raw, vsync_raw;

    always_comb begin
        h_last     = (hcnt_q == H_MAX);
        v_last     = (vcnt_q == V_MAX);
        frame_wrap = h_last && v_last;

        hcnt_d = h_last ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (h_last) begin
            vcnt_d = v_last ? 10'd0 : vcnt_q + 10'd1;
        end

        frame_start_d = frame_wrap;
        frame_count_d = frame_wrap ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            frame_start_q <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        hsync_raw = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
        vsync_raw = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
    end

    // Syncs lag the coordinates so they line up with renderer colour output.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs = hsync_raw;
            assign vs = vsync_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe_q;
            logic [SYNC_DELAY-1:0] vs_pipe_q;

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                end else begin
                    hs_pipe_q[0] <= hsync_raw;
                    vs_pipe_q[0] <= vsync_raw;
                    for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                    end
                end
            end

            assign hs = hs_pipe_q[SYNC_DELAY-1];
            assign vs = vs_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

    assign DrawX       = hcnt_q;
    assign DrawY       = vcnt_q;
    assign blank       = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign sync        = 1'b0;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing plus two reduced-size builds
// (sync delay 2 and 0) for frame wrap, vsync and counter rollover.
module tb_vga_timing_gen;

    logic        clk;
    logic        rst_b, rst_s;

    logic [9:0]  b_x, b_y, m_x, m_y, s_x, s_y;
    logic        b_blank, b_hs, b_vs, b_sync, b_fs;
    logic        m_blank, m_hs, m_vs, m_sync, m_fs;
    logic        s_blank, s_hs, s_vs, s_sync, s_fs;
    logic [15:0] b_fc, m_fc, s_fc;

    int vectors;
    int miscompares;

    vga_timing_gen u_big (
        .vga_clk(clk), .reset(rst_b),
        .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
        .hs(b_hs), .vs(b_vs), .sync(b_sync),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_DELAY(2)
    ) u_med (
        .vga_clk(clk), .reset(rst_s),
        .DrawX(m_x), .DrawY(m_y), .blank(m_blank),
        .hs(m_hs), .vs(m_vs), .sync(m_sync),
        .frame_start(m_fs), .frame_count(m_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_DELAY(0)
    ) u_sml (
        .vga_clk(clk), .reset(rst_s),
        .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
        .hs(s_hs), .vs(s_vs), .sync(s_sync),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_big_reset(input string tag);
        chk({tag, " big DrawX"}, 32'(b_x), 0);
        chk({tag, " big DrawY"}, 32'(b_y), 0);
        chk({tag, " big hs"}, 32'(b_hs), 1);
        chk({tag, " big vs"}, 32'(b_vs), 1);
        chk({tag, " big frame_start"}, 32'(b_fs), 0);
        chk({tag, " big frame_count"}, 32'(b_fc), 0);
        chk({tag, " big blank"}, 32'(b_blank), 1);
        chk({tag, " big sync"}, 32'(b_sync), 0);
    endtask

    initial begin
        int x, y, xd, yd;
        vectors     = 0;
        miscompares = 0;
        rst_b = 1'b1;
        rst_s = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_big_reset("por");
        chk("por med DrawX", 32'(m_x), 0);
        chk("por med vs", 32'(m_vs), 1);
        chk("por sml frame_count", 32'(s_fc), 0);

        @(negedge clk);
        rst_b = 1'b0;
        rst_s = 1'b0;

        for (int e = 1; e <= 1100; e++) begin
            @(posedge clk);
            #1;
            // full-size: DrawX/DrawY track edge count, syncs lag by 2
            x  = e % 800;
            y  = e / 800;
            xd = (e - 2) % 800;
            chk("big DrawX", 32'(b_x), x);
            chk("big DrawY", 32'(b_y), y);
            chk("big blank", 32'(b_blank), (x < 640) && (y < 480));
            chk("big hs", 32'(b_hs), (e < 2) ? 1 : !((xd >= 656) && (xd < 752)));
            chk("big vs", 32'(b_vs), 1);
            chk("big sync", 32'(b_sync), 0);
            chk("big frame_start", 32'(b_fs), 0);

            if (e <= 300) begin
                x  = e % 14;
                y  = (e / 14) % 7;
                xd = (e - 2) % 14;
                yd = ((e - 2) / 14) % 7;
                chk("med DrawX", 32'(m_x), x);
                chk("med DrawY", 32'(m_y), y);
                chk("med blank", 32'(m_blank), (x < 8) && (y < 4));
                chk("med hs", 32'(m_hs), (e < 2) ? 1 : !((xd >= 10) && (xd < 12)));
                chk("med vs", 32'(m_vs), (e < 2) ? 1 : (yd != 5));
                chk("med frame_start", 32'(m_fs), (e % 98) == 0);
                chk("med frame_count", 32'(m_fc), e / 98);
                chk("sml hs", 32'(s_hs), !((x >= 10) && (x < 12)));
                chk("sml vs", 32'(s_vs), y != 5);
                chk("sml sync", 32'(s_sync), 0);
                chk("sml frame_start", 32'(s_fs), (e % 98) == 0);
                chk("sml frame_count", 32'(s_fc), e / 98);
            end

            if (e == 400) force u_sml.frame_count_q = 16'hFFFF;
            if (e == 489) release u_sml.frame_count_q;
            if (e == 490) begin
                chk("rollover DrawX", 32'(s_x), 0);
                chk("rollover DrawY", 32'(s_y), 0);
                chk("rollover frame_start", 32'(s_fs), 1);
                chk("rollover frame_count", 32'(s_fc), 0);
            end
            if (e == 491) begin
                chk("post-rollover frame_start", 32'(s_fs), 0);
                chk("post-rollover frame_count", 32'(s_fc), 0);
            end
            if (e == 658) chk("big hs falls at 658", 32'(b_hs), 0);
            if (e == 754) chk("big hs rises at 754", 32'(b_hs), 1);
        end

        // mid-frame asynchronous reset: big at (300,1), med has 11 frames
        #2;
        rst_b = 1'b1;
        rst_s = 1'b1;
        #1;
        chk_big_reset("async");
        chk("async med DrawX", 32'(m_x), 0);
        chk("async med DrawY", 32'(m_y), 0);
        chk("async med frame_count", 32'(m_fc), 0);
        chk("async med hs", 32'(m_hs), 1);

        @(posedge clk);
        #1;
        chk_big_reset("held");

        @(negedge clk);
        rst_b = 1'b0;
        rst_s = 1'b0;
        @(posedge clk);
        #1;
        chk("restart big DrawX", 32'(b_x), 1);
        chk("restart big DrawY", 32'(b_y), 0);
        chk("restart med DrawX", 32'(m_x), 1);
        chk("restart med frame_start", 32'(m_fs), 0);
        chk("restart med frame_count", 32'(m_fc), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing on vga_clk (25 MHz pixel clock).
- Drives DrawX/DrawY/blank into every per-pixel renderer (floor, tank and sprite ROM layers) and drives hs/vs to the connector.
- hs/vs are delayed by a programmable pipeline depth so they stay aligned with renderer colour outputs, which lag DrawX/DrawY by ROM read plus output register.
- Also provides a frame-start strobe and a frame counter for game-logic pacing.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_DELAY, 2, pipeline delay (cycles, 0..7) applied to hs/vs relative to DrawX/DrawY

Ports:
vga_clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
DrawX  output  10  current horizontal counter (0..H_TOTAL-1)
DrawY  output  10  current vertical counter (0..V_TOTAL-1)
blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
hs  output  1  horizontal sync, active low, delayed SYNC_DELAY cycles
vs  output  1  vertical sync, active low, delayed SYNC_DELAY cycles
sync  output  1  composite sync for DAC, constant 0
frame_start  output  1  one-cycle strobe on arrival at (0,0) via wrap
frame_count  output  16  frames completed since reset, wraps 65535->0

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525); 420000 cycles per frame.
- Reset (asynchronous, active-high): DrawX=0, DrawY=0, hs=1, vs=1, all delay stages=1, frame_start=0, frame_count=0. blank reads 1 during reset, since it is combinational from counters at (0,0). sync=0 always.
- DrawX: increments every cycle; at H_TOTAL-1 it wraps to 0.
- DrawY: increments only on the DrawX wrap; at V_TOTAL-1 with DrawX=H_TOTAL-1 both wrap to 0.
- blank: combinational from the counter registers, same cycle as DrawX/DrawY, no delay. Renderers sample it alongside the coordinates.
- Raw hsync: low when H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- Raw vsync: low when V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491. Applies for whole lines.
- hs/vs: raw values passed through a SYNC_DELAY-deep shift register. SYNC_DELAY=0 means combinational from counters.
- frame_start: registered. Set to 1 on the edge where the counters wrap (799,524)->(0,0); cleared on the next edge.
  - High exactly while DrawX=0, DrawY=0 after a wrap.
  - No pulse for the first frame following reset release.
- frame_count: increments on the same edge that sets frame_start; 16-bit modular.
- Reset mid-frame: all state returns to reset values immediately (async). Counting resumes from (0,0) on the first edge after deassertion. frame_count restarts at 0.
- No enables or stalls: the counter free-runs whenever reset=0.

Test Plan:
- Reset values: assert reset with counters mid-frame (DrawX=300, DrawY=200) -> immediately DrawX=0, DrawY=0, hs=1, vs=1, frame_start=0, frame_count=0, blank=1.
- hs timing, SYNC_DELAY=2: release reset; DrawX=656 at edge 656 -> hs falls on edge 658, stays low 96 cycles, rises on edge 754. blank=0 from DrawX=640 to 799, back to 1 at DrawX=0, DrawY=1.
- vs timing: vs low for exactly 1600 cycles, starting 2 cycles after DrawY becomes 490 with DrawX=0. blank=0 throughout lines 480..524.
- Frame wrap: after 420000 edges from reset release -> DrawX=0, DrawY=0, frame_start=1 for one cycle, frame_count=1. After 2 frames -> frame_count=2; no pulse at edge 0.
- Counter wrap: force frame_count=65535 (or run via a small-parameter build) -> next frame wrap gives frame_count=0 and frame_start=1.
- SYNC_DELAY=0 with small parameters (H 8/2/2/2, V 4/1/1/1) -> hs low exactly while DrawX in 10..11, same cycle. Frame period = 14*7 = 98 cycles.
